// File: rtl/mul4_seq_pkg.sv
// Shared types and constants for the mul4_seq shift-add multiplier.
package mul4_seq_pkg;
  localparam int WIDTH = 4;
  localparam int STEPS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mul4_seq_if.sv
// Start/busy/done handshake and operand/product bus for mul4_seq.
interface mul4_seq_if;
  import mul4_seq_pkg::*;

  logic                   START;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic                   BUSY;
  logic                   DONE;
  logic [2*WIDTH-1:0]     P;

  modport master (output START, A, B, input BUSY, DONE, P);
  modport slave  (input START, A, B, output BUSY, DONE, P);
endinterface

// File: rtl/add_fast.sv
// 4-bit carry look-ahead adder (ADD_FAST): S/CO = A + B + CI.
module ADD_FAST (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CI,
  output logic [3:0] S,
  output logic       CO
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  assign c[0] = CI;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign S  = p ^ c[3:0];
  assign CO = c[4];
endmodule

// File: rtl/mul4_ctrl.sv
// Sequencer for mul4_seq: FSM plus step and settle counters.
//   state   | meaning
//   ST_IDLE | waiting for start; load operands on accept
//   ST_CALC | one commit every SETTLE_CYCLES cycles, four commits total
//   ST_DONE | one-cycle done pulse, product valid
module mul4_ctrl
  import mul4_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic start,
  input  logic bypass,
  output logic load,
  output logic commit,
  output logic fin,
  output logic done,
  output logic busy
);
  localparam logic [2:0] SET_LAST  = 3'(SETTLE_CYCLES - 1);
  localparam logic [2:0] STEP_LAST = 3'(STEPS - 1);

  state_t     state, state_nx;
  logic [2:0] step_cnt, step_nx;
  logic [2:0] set_cnt, set_nx;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      set_cnt  <= '0;
    end else begin
      state    <= state_nx;
      step_cnt <= step_nx;
      set_cnt  <= set_nx;
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step_cnt;
    set_nx   = set_cnt;
    load     = 1'b0;
    commit   = 1'b0;
    fin      = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          step_nx = '0;
          set_nx  = '0;
          if (bypass) begin
            fin      = 1'b1;
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        // set_cnt never exceeds SET_LAST, so != is the "still settling" test
        if (set_cnt != SET_LAST) begin
          set_nx = set_cnt + 3'd1;
        end else begin
          commit  = 1'b1;
          set_nx  = '0;
          step_nx = step_cnt + 3'd1;
          if (step_cnt == STEP_LAST) begin
            fin      = 1'b1;
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-add multiplier built around ADD_FAST.
// Optional MUL4_ZERO_BYPASS_EN: a zero operand skips CALC and finishes in one cycle.
module mul4_seq
  import mul4_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  mul4_seq_if.slave  bus
);
  logic [WIDTH-1:0]   m_reg, h_reg, q_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [WIDTH-1:0]   sum;
  logic               co;
  logic [WIDTH:0]     x;
  logic               load, commit, fin, done, busy, bypass;

  ADD_FAST u_add (
    .A  (h_reg),
    .B  (m_reg),
    .CI (1'b0),
    .S  (sum),
    .CO (co)
  );

  // CO is kept as x[WIDTH] so the carry shifts into H instead of being lost
  assign x = q_reg[0] ? {co, sum} : {1'b0, h_reg};

`ifdef MUL4_ZERO_BYPASS_EN
  assign bypass = (bus.A == '0) || (bus.B == '0);
`else
  assign bypass = 1'b0;
`endif

  mul4_ctrl #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_ctrl (
    .clk_sys (CLK),
    .rst     (RST),
    .start   (bus.START),
    .bypass  (bypass),
    .load    (load),
    .commit  (commit),
    .fin     (fin),
    .done    (done),
    .busy    (busy)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_reg <= '0;
      h_reg <= '0;
      q_reg <= '0;
      p_reg <= '0;
    end else begin
      if (load) begin
        m_reg <= bus.A;
        q_reg <= bus.B;
        h_reg <= '0;
      end else if (commit) begin
        h_reg <= x[WIDTH:1];
        q_reg <= {x[0], q_reg[WIDTH-1:1]};
      end
      // product captured from the final shift so it is valid during DONE
      if (fin) p_reg <= load ? '0 : {x, q_reg[WIDTH-1:1]};
    end
  end

  assign bus.BUSY = busy;
  assign bus.DONE = done;
  assign bus.P    = p_reg;
endmodule

// File: tb/tb_mul4_seq.sv
// Self-checking bench for mul4_seq: SETTLE_CYCLES=1 and =3 instances vs. an arithmetic model.
module tb_mul4_seq;
`ifdef MUL4_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk, rst, start, sel;
  logic [3:0] ina, inb;
  logic       busy_s, done_s;
  logic [7:0] p_s;
  logic [7:0] last_p1, last_p3;
  int         pass_cnt, chk_cnt;

  mul4_seq_if if1();
  mul4_seq_if if3();

  assign if1.START = start & ~sel;
  assign if1.A     = ina;
  assign if1.B     = inb;
  assign if3.START = start & sel;
  assign if3.A     = ina;
  assign if3.B     = inb;

  assign busy_s = sel ? if3.BUSY : if1.BUSY;
  assign done_s = sel ? if3.DONE : if1.DONE;
  assign p_s    = sel ? if3.P    : if1.P;

  mul4_seq #(.SETTLE_CYCLES(1)) dut1 (.CLK(clk), .RST(rst), .bus(if1));
  mul4_seq #(.SETTLE_CYCLES(3)) dut3 (.CLK(clk), .RST(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [3:0] a, input logic [3:0] b, input int s);
    if (BYPASS && (a == 4'd0 || b == 4'd0)) return 1;
    return 4 * s + 1;
  endfunction

  // Runs one operation on the selected DUT (must be idle) and checks it.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit full, output bit ok);
    int lat, busy_n, settle, fails0, elat;
    logic [7:0] exp_p, held;
    bit p_moved;
    fails0 = chk_cnt - pass_cnt;
    settle = sel ? 3 : 1;
    held   = sel ? last_p3 : last_p1;
    exp_p  = 8'({4'd0, a} * {4'd0, b});
    elat   = exp_lat(a, b, settle);
    start = 1'b1; ina = a; inb = b;
    tick();
    start = 1'b0; ina = 4'($urandom); inb = 4'($urandom);
    lat = 1; busy_n = 0; p_moved = 1'b0;
    while (!done_s && lat < 40) begin
      if (busy_s) busy_n++;
      if (busy_s && p_s !== held) p_moved = 1'b1;
      tick();
      lat++;
    end
    chk_cnt++;
    if (done_s !== 1'b1) $display("FAIL op_timeout %0d*%0d: done=%b required 1", a, b, done_s);
    else pass_cnt++;
    chk_cnt++;
    if (p_s !== exp_p) $display("FAIL product %0d*%0d: got %0d required %0d", a, b, p_s, exp_p);
    else pass_cnt++;
    chk_cnt++;
    if (lat != elat) $display("FAIL latency %0d*%0d: got %0d required %0d", a, b, lat, elat);
    else pass_cnt++;
    if (full) begin
      chk_cnt++;
      if (busy_n != elat - 1) $display("FAIL busy_cycles %0d*%0d: got %0d required %0d", a, b, busy_n, elat - 1);
      else pass_cnt++;
      chk_cnt++;
      if (p_moved) $display("FAIL p_stable %0d*%0d: P changed while busy, required %0d", a, b, held);
      else pass_cnt++;
    end
    tick();
    if (full) begin
      chk_cnt++;
      if (done_s !== 1'b0) $display("FAIL done_pulse %0d*%0d: done=%b required 0", a, b, done_s);
      else pass_cnt++;
    end
    if (sel) last_p3 = exp_p; else last_p1 = exp_p;
    ok = ((chk_cnt - pass_cnt) == fails0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel = 1'b0; ina = 4'd0; inb = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_cnt++;
    if ({if1.BUSY, if1.DONE} !== 2'b00) $display("FAIL reset_flags1: got %b required 00", {if1.BUSY, if1.DONE});
    else pass_cnt++;
    chk_cnt++;
    if (if1.P !== 8'h00) $display("FAIL reset_p1: got %h required 00", if1.P);
    else pass_cnt++;
    chk_cnt++;
    if ({if3.BUSY, if3.DONE, if3.P} !== 10'd0) $display("FAIL reset_dut3: got %b required 0", {if3.BUSY, if3.DONE, if3.P});
    else pass_cnt++;
    last_p1 = 8'h00; last_p3 = 8'h00;
  endtask

  task automatic test_directed();
    bit ok;
    run_op(4'd15, 4'd15, 1'b1, ok);
    run_op(4'd3,  4'd5,  1'b1, ok);
    run_op(4'd9,  4'd0,  1'b1, ok);
    run_op(4'd0,  4'd7,  1'b1, ok);
  endtask

  task automatic test_back_to_back();
    int lat;
    sel = 1'b0;
    start = 1'b1; ina = 4'd7; inb = 4'd6;
    tick();
    ina = 4'd15; inb = 4'd15;
    lat = 1;
    while (!done_s && lat < 40) begin tick(); lat++; end
    chk_cnt++;
    if (p_s !== 8'd42) $display("FAIL b2b_first: got %0d required 42", p_s);
    else pass_cnt++;
    chk_cnt++;
    if (lat != 5) $display("FAIL b2b_latency: got %0d required 5", lat);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({busy_s, done_s} !== 2'b00) $display("FAIL b2b_idle_gap: got %b required 00", {busy_s, done_s});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (busy_s !== 1'b1) $display("FAIL b2b_second_start: busy=%b required 1", busy_s);
    else pass_cnt++;
    start = 1'b0;
    lat = 0;
    while (!done_s && lat < 40) begin tick(); lat++; end
    chk_cnt++;
    if (p_s !== 8'd225) $display("FAIL b2b_second: got %0d required 225", p_s);
    else pass_cnt++;
    tick();
    last_p1 = 8'd225;
  endtask

  task automatic test_abort();
    int dones;
    bit ok;
    sel = 1'b0;
    start = 1'b1; ina = 4'd12; inb = 4'd13;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++;
    if ({busy_s, done_s} !== 2'b00) $display("FAIL abort_flags: got %b required 00", {busy_s, done_s});
    else pass_cnt++;
    chk_cnt++;
    if (p_s !== 8'h00) $display("FAIL abort_p: got %h required 00", p_s);
    else pass_cnt++;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_s) dones++;
      tick();
    end
    chk_cnt++;
    if (dones != 0) $display("FAIL abort_no_done: got %0d pulses required 0", dones);
    else pass_cnt++;
    last_p1 = 8'h00; last_p3 = 8'h00;
    run_op(4'd12, 4'd13, 1'b1, ok);
  endtask

  task automatic test_random();
    bit ok;
    sel = 1'b0;
    for (int i = 0; i < 20; i++) run_op(4'($urandom), 4'($urandom), 1'b1, ok);
  endtask

  task automatic test_settle3();
    bit ok;
    sel = 1'b1;
    run_op(4'd10, 4'd11, 1'b1, ok);
    run_op(4'd0,  4'd5,  1'b1, ok);
    for (int i = 0; i < 5; i++) run_op(4'($urandom), 4'($urandom), 1'b1, ok);
    sel = 1'b0;
  endtask

  task automatic test_sweep();
    bit ok;
    int wrong;
    sel = 1'b0;
    wrong = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 1'b0, ok);
        if (!ok) wrong++;
      end
    $display("sweep: %0d of 256 pairs wrong", wrong);
  endtask

  initial begin
    pass_cnt = 0; chk_cnt = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort();
    test_random();
    test_settle3();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
